// File: rtl/line_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : line_fill_ctrl
// Critical-word-first cache line refill over a single-word memory port.
// Rev    : 1.0
// ============================================================================
module line_fill_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT        = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             fill_req,
  input  logic [31:0]                      fill_addr,
  output logic                             fill_ready,
  output logic                             mem_req,
  output logic [63:0]                      mem_addr,
  input  logic                             mem_ack,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic                             crit_valid,
  output logic [DATA_W-1:0]                crit_data,
  output logic                             fill_valid,
  output logic [31:0]                      fill_base,
  output logic [WORDS_PER_LINE*DATA_W-1:0] fill_line,
  output logic                             fill_err
);

  localparam int         c_line_w     = WORDS_PER_LINE * DATA_W;
  localparam logic [7:0] c_wait_limit = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [29:0]         r_base;
  logic [1:0]          r_offset;
  logic [1:0]          r_beat;
  logic [7:0]          r_wait;
  logic [c_line_w-1:0] r_line_buf;
  logic                r_mem_req;
  logic [63:0]         r_mem_addr;
  logic                r_crit_valid;
  logic [DATA_W-1:0]   r_crit_data;
  logic                r_fill_valid;
  logic [31:0]         r_fill_base;
  logic [c_line_w-1:0] r_fill_line;
  logic                r_fill_err;

  logic [1:0]          w_idx;
  logic [1:0]          w_idx_next;
  logic                w_accept;
  logic                w_ack;
  logic                w_last;
  logic                w_timeout;
  logic [c_line_w-1:0] w_line_merged;

  assign w_idx      = r_offset + r_beat;
  assign w_idx_next = w_idx + 2'd1;
  assign w_accept   = (r_state == S_IDLE) && fill_req;
  assign w_ack      = (r_state == S_FETCH) && mem_ack;
  assign w_last     = w_ack && (r_beat == 2'd3);
  assign w_timeout  = (r_state == S_FETCH) && !mem_ack && (r_wait == c_wait_limit);

  // Line buffer with the arriving word already inserted, so the final beat
  // can publish the complete line in the same edge.
  always_comb begin
    w_line_merged = r_line_buf;
    w_line_merged[int'(w_idx)*DATA_W +: DATA_W] = mem_rdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (fill_req) w_state_next = S_FETCH;
      S_FETCH: begin
        if (w_last)         w_state_next = S_DONE;
        else if (w_timeout) w_state_next = S_ERR;
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base       <= '0;
      r_offset     <= '0;
      r_beat       <= '0;
      r_wait       <= '0;
      r_line_buf   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      r_fill_valid <= 1'b0;
      r_fill_base  <= '0;
      r_fill_line  <= '0;
      r_fill_err   <= 1'b0;
    end else begin
      r_crit_valid <= 1'b0;
      r_fill_valid <= 1'b0;
      r_fill_err   <= 1'b0;
      if (w_accept) begin
        r_base     <= fill_addr[31:2];
        r_offset   <= fill_addr[1:0];
        r_beat     <= 2'd0;
        r_wait     <= 8'd0;
        r_mem_req  <= 1'b1;
        r_mem_addr <= {32'd0, fill_addr};
      end
      if (w_ack) begin
        r_line_buf <= w_line_merged;
        r_beat     <= r_beat + 2'd1;
        r_wait     <= 8'd0;
        r_mem_addr <= {32'd0, r_base, w_idx_next};
        if (r_beat == 2'd0) begin
          r_crit_data  <= mem_rdata;
          r_crit_valid <= 1'b1;
        end
        if (w_last) begin
          r_mem_req    <= 1'b0;
          r_fill_valid <= 1'b1;
          r_fill_line  <= w_line_merged;
          r_fill_base  <= {r_base, 2'b00};
        end
      end else if (r_state == S_FETCH) begin
        if (w_timeout) begin
          r_mem_req  <= 1'b0;
          r_fill_err <= 1'b1;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end
    end
  end

  assign fill_ready = (r_state == S_IDLE);
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
  assign fill_valid = r_fill_valid;
  assign fill_base  = r_fill_base;
  assign fill_line  = r_fill_line;
  assign fill_err   = r_fill_err;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_line_fill_ctrl
// Randomized self-checking bench for line_fill_ctrl against a line-level model.
// Rev    : 1.0
// ============================================================================
module tb_line_fill_ctrl;

  localparam int TIMEOUT = 64;

  logic         clock;
  logic         reset;
  logic         fill_req;
  logic [31:0]  fill_addr;
  logic         fill_ready;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_ack;
  logic [63:0]  mem_rdata;
  logic         crit_valid;
  logic [63:0]  crit_data;
  logic         fill_valid;
  logic [31:0]  fill_base;
  logic [255:0] fill_line;
  logic         fill_err;

  int n_checks = 0;
  int n_errors = 0;
  int waits[4];
  logic [255:0] m_line;
  logic [31:0]  m_base;

  line_fill_ctrl #(
    .WORDS_PER_LINE(4),
    .DATA_W        (64),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fill_req  (fill_req),
    .fill_addr (fill_addr),
    .fill_ready(fill_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .crit_valid(crit_valid),
    .crit_data (crit_data),
    .fill_valid(fill_valid),
    .fill_base (fill_base),
    .fill_line (fill_line),
    .fill_err  (fill_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ram(input logic [63:0] a);
    return a * a;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_fill_ready", fill_ready, 1);
    chk("rst_mem_req",    mem_req,    0);
    chk("rst_mem_addr",   mem_addr,   0);
    chk("rst_crit_valid", crit_valid, 0);
    chk("rst_crit_data",  crit_data,  0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_base",  fill_base,  0);
    chk("rst_fill_line",  fill_line,  0);
    chk("rst_fill_err",   fill_err,   0);
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      chk("idle_ready",      fill_ready, 1);
      chk("idle_mem_req",    mem_req,    0);
      chk("idle_fill_valid", fill_valid, 0);
      chk("idle_fill_err",   fill_err,   0);
      fill_req  = 1'b0;
      mem_ack   = 1'($urandom % 2);
      mem_rdata = {$urandom, $urandom};
    end
    mem_ack = 1'b0;
  endtask

  // One complete request; waits[b] idle cycles precede the ack of beat b,
  // and waits[b] >= TIMEOUT means that beat is never acknowledged.
  task automatic do_fill(input logic [31:0] addr, input bit busy);
    logic [31:0]  base;
    logic [1:0]   off;
    logic [255:0] exp_line;
    int           n;
    bit           tmo;
    base = addr & ~32'd3;
    off  = addr[1:0];
    for (int k = 0; k < 4; k++) exp_line[64*k +: 64] = ram(64'(base) + 64'(k));
    @(negedge clock);
    chk("ready_before", fill_ready, 1);
    fill_req  = 1'b1;
    fill_addr = addr;
    mem_ack   = 1'b0;
    n   = 0;
    tmo = 1'b0;
    for (int b = 0; b < 4 && !tmo; b++) begin
      for (int c = 0; c < TIMEOUT; c++) begin
        @(negedge clock);
        n++;
        fill_req  = busy && (n == 2);
        fill_addr = (busy && n == 2) ? 32'd40 : addr;
        chk("mem_req",    mem_req, 1);
        chk("mem_addr",   mem_addr, 64'(base) + 64'((int'(off) + b) % 4));
        chk("ready_busy", fill_ready, 0);
        chk("valid_busy", fill_valid, 0);
        chk("crit_valid", crit_valid, (b == 1 && c == 0));
        if (b == 1 && c == 0) chk("crit_data", crit_data, ram(64'(addr)));
        mem_ack   = (c == waits[b]);
        mem_rdata = mem_ack ? ram(mem_addr) : {$urandom, $urandom};
        if (mem_ack) break;
        if (c == TIMEOUT - 1) tmo = 1'b1;
      end
    end
    @(negedge clock);
    fill_req = 1'b0;
    mem_ack  = 1'b0;
    chk("end_mem_req", mem_req, 0);
    chk("end_ready",   fill_ready, 0);
    if (!tmo) begin
      chk("fill_valid",     fill_valid, 1);
      chk("fill_err_ok",    fill_err,   0);
      chk("fill_base",      fill_base,  base);
      chk("fill_line",      fill_line,  exp_line);
      chk("crit_data_hold", crit_data,  ram(64'(addr)));
      m_line = exp_line;
      m_base = base;
    end else begin
      chk("fill_err",       fill_err,   1);
      chk("no_fill_valid",  fill_valid, 0);
      chk("line_kept",      fill_line,  m_line);
      chk("base_kept",      fill_base,  m_base);
    end
    @(negedge clock);
    chk("ready_after", fill_ready, 1);
    chk("valid_after", fill_valid, 0);
    chk("err_after",   fill_err,   0);
  endtask

  task automatic set_waits(input int w0, input int w1, input int w2, input int w3);
    waits[0] = w0; waits[1] = w1; waits[2] = w2; waits[3] = w3;
  endtask

  initial begin
    reset     = 1'b0;
    fill_req  = 1'b0;
    fill_addr = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    m_line    = '0;
    m_base    = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;
    idle(2);

    set_waits(0, 0, 0, 0);           do_fill(32'd16, 1'b0);
    set_waits(0, 0, 0, 0);           do_fill(32'd26, 1'b0);
    set_waits(3, 3, 3, 3);           do_fill(32'd0,  1'b0);
    set_waits(TIMEOUT, 0, 0, 0);     do_fill(32'd4,  1'b0);
    set_waits(TIMEOUT - 1, 0, 0, 0); do_fill(32'd7,  1'b0);
    set_waits(0, 1, TIMEOUT, 0);     do_fill(32'd13, 1'b0);
    set_waits(0, 0, 0, 0);           do_fill(32'd16, 1'b1);

    // Asynchronous reset after two beats of a fill to line 8.
    @(negedge clock);
    fill_req  = 1'b1;
    fill_addr = 32'd8;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      fill_req  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = ram(mem_addr);
    end
    @(negedge clock);
    mem_ack = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clock);
    reset  = 1'b1;
    m_line = '0;
    m_base = '0;
    idle(3);
    set_waits(0, 0, 0, 0);           do_fill(32'd0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int b = 0; b < 4; b++) begin
        int r;
        r = int'($urandom % 24);
        waits[b] = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : r % 4;
      end
      idle(int'($urandom % 3));
      do_fill($urandom, 1'($urandom % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_fill_ctrl.md
# line_fill_ctrl

Line-refill controller between the cache and main memory. On a miss, it accepts one line-fill request and fetches the 4-word line as a critical-word-first burst of single-word reads. It handles variable memory latency and assembles the line into one wide output. It reports the critical word early, signals completion with a one-cycle pulse, and aborts on a memory timeout.

## Interface
- WORDS_PER_LINE, 4, words per cache line; fixed at 4, and offset logic is 2 bits.
- DATA_W, 64, memory word width.
- TIMEOUT, 64, maximum wait in cycles for a single memory ack (1..255).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- fill_req  in  1  fill request; sampled only while fill_ready=1.
- fill_addr  in  32  word address of the missing word. Line base = fill_addr & ~3; offset = fill_addr[1:0].
- fill_ready  out  1  controller is idle and can accept a request.
- mem_req  out  1  memory read request; held high until acked.
- mem_addr  out  64  word address being read (zero-extended).
- mem_ack  in  1  mem_rdata is valid this cycle; meaningful only while mem_req=1.
- mem_rdata  in  64  read data.
- crit_valid  out  1  one-cycle pulse: crit_data holds the requested word.
- crit_data  out  64  critical word.
- fill_valid  out  1  one-cycle pulse: the line is complete.
- fill_base  out  32  line base address of the completed fill.
- fill_line  out  256  assembled line; word k occupies bits [64k+63:64k].
- fill_err  out  1  one-cycle pulse: the fill was aborted by timeout.

## Operation
- States:
  - IDLE: fill_ready=1. On fill_req, latch base and offset, set beat=0, go to FETCH.
  - FETCH: mem_req=1, mem_addr = base + ((offset+beat) mod 4).
    - On mem_ack, write mem_rdata into line word (offset+beat) mod 4 and increment beat.
    - After beat 3 acks, go to DONE.
  - DONE: fill_valid=1 for one cycle, then go to IDLE.
  - ERR: fill_err=1 for one cycle, then go to IDLE.
- Wrap order: offset o gives the sequence o, o+1, o+2, o+3, each mod 4.
- Critical word: on the first ack, crit_data is loaded and crit_valid pulses in the next cycle.
- Timeout:
  - An 8-bit wait counter clears on each ack and on entry to FETCH.
  - It increments on each FETCH cycle with no ack.
  - When the counter equals TIMEOUT-1 and there is no ack this cycle, go to ERR.
  - fill_valid is never asserted for an aborted fill.
- fill_line and fill_base hold their values until the next completed fill. Partial-line writes are visible internally only; fill_line is updated as a whole in DONE.
- fill_req while not ready: ignored, not queued. mem_ack while mem_req=0: ignored.
- Reset asserted, including mid-fill: asynchronous return to IDLE. Beat, wait counter and line register are cleared. Any fill in progress is dropped with no pulse.

## Timing
- Reset values:
  - fill_ready=1.
  - mem_req=0, mem_addr=0.
  - crit_valid=0, crit_data=0.
  - fill_valid=0, fill_base=0, fill_line=0, fill_err=0.
- Cycle numbering: request accepted at edge 0.
  - mem_req rises in cycle 1.
  - Zero-wait memory (mem_ack tied high): beats occur in cycles 1-4, crit_valid in cycle 2, fill_valid in cycle 5, fill_ready in cycle 6.
  - Each wait cycle on a beat delays all later events by one cycle.
- mem_addr changes only on the cycle after an ack, or on entry to FETCH; it is stable while mem_req is waiting.
- All outputs are registered, except fill_ready, which is decoded from state.

## Test plan
Memory model in all scenarios: RAM[i]=i*i.
- Zero-wait fill, fill_addr=16:
  - mem_addr is 16, 17, 18, 19 in cycles 1-4; crit_data=256 in cycle 2.
  - fill_valid in cycle 5 with fill_base=16 and fill_line words {256, 289, 324, 361}.
- Critical-word-first, fill_addr=26:
  - mem_addr is 26, 27, 24, 25; crit_data=676 in cycle 2.
  - fill_line = {576, 625, 676, 729}, fill_base=24.
- Wait states, fill_addr=0, ack arrives on the 4th cycle of each beat:
  - mem_addr is held 4 cycles per beat; fill_valid in cycle 17 with line {0, 1, 4, 9}.
- Timeout, TIMEOUT=64, mem_ack never asserted:
  - mem_req is high in cycles 1-64; fill_err pulses in cycle 65; fill_ready in cycle 66.
  - No fill_valid; fill_line keeps its previous value.
- Reset mid-fill, asserted after 2 acks of fill_addr=8:
  - All outputs take their reset values immediately; no fill_valid.
  - A following fill_addr=0 returns {0, 1, 4, 9}.
- Busy request, second fill_req (addr 40) in cycle 2 of a fill to addr 16:
  - The second request is ignored; only line 16 completes, and mem_addr never equals 40.
